dot_product_scheduler: RTL and testbench
========================================

Name: dot_product_scheduler

Overview:
Sequences the floating-point dot-product unit over vectors longer than its NUM_INPUTS lanes. A vector arrives as a stream of NUM_INPUTS-wide chunks. Each chunk is issued to the unit with the running partial sum on its c input, and the next chunk waits for the previous result. The final chunk is lane-masked through enable. Sits between the spectral-vector fetch logic and the dot-product datapath, and returns one scalar per vector with a valid/ready handshake.

Parameters:
WIDTH, 32, floating-point word width (IEEE-754 single)
NUM_INPUTS, 7, lanes per chunk; must match the datapath
MAX_LEN, 256, maximum vector length in elements
LEN_W, $clog2(MAX_LEN+1), width of the length field
TIMEOUT, 64, maximum cycles to wait for a datapath result before flagging an error

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  start pulse, sampled in IDLE only
cfg_len  in  LEN_W  vector length in elements, latched on start
busy  out  1  high in every state except IDLE
in_a  in  WIDTH*NUM_INPUTS  chunk operand A, lane 0 in the LSBs
in_b  in  WIDTH*NUM_INPUTS  chunk operand B
in_valid  in  1  chunk present
in_ready  out  1  scheduler accepts a chunk
dp_a  out  WIDTH*NUM_INPUTS  registered operand A to the datapath
dp_b  out  WIDTH*NUM_INPUTS  registered operand B to the datapath
dp_c  out  WIDTH  running partial sum to the datapath
dp_enable  out  NUM_INPUTS  lane mask to the datapath
dp_ready  out  1  one-cycle issue strobe to the datapath
dp_valid  in  1  datapath result strobe
dp_out  in  WIDTH  datapath result
res_data  out  WIDTH  final dot product
res_err  out  1  result aborted by timeout
res_valid  out  1  result available
res_ready  in  1  consumer accepts the result

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0: dp_a, dp_b, dp_c, dp_enable, dp_ready, in_ready, busy, res_data, res_err, res_valid.
  - Accumulator, chunk counter and watchdog cleared.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On start: latch len = min(cfg_len, MAX_LEN); num_chunks = ceil(len/NUM_INPUTS); acc = 0x00000000; chunk_cnt = 0.
  - If len == 0, go to DONE with res_data = 0 and res_err = 0. Otherwise go to ISSUE.
  - start outside IDLE is ignored.
- ISSUE:
  - in_ready=1 combinationally.
  - On in_valid & in_ready:
    - Register in_a/in_b into dp_a/dp_b and set dp_c = acc.
    - dp_enable = all ones, except on the last chunk (chunk_cnt == num_chunks-1), where it is the low (len mod NUM_INPUTS) bits set. If that remainder is 0, all ones.
    - dp_ready is high for exactly the following cycle.
    - Go to WAIT and clear the watchdog.
- WAIT:
  - in_ready=0; watchdog increments each cycle.
  - On dp_valid: acc <= dp_out and chunk_cnt++. Go to DONE with res_data = dp_out if this was the last chunk, else back to ISSUE.
  - dp_valid and watchdog == TIMEOUT-1 in the same cycle: dp_valid wins.
  - Watchdog reaches TIMEOUT-1 without dp_valid: go to DONE with res_err = 1 and res_data = acc.
- DONE:
  - res_valid=1; res_data and res_err held stable.
  - On res_ready: res_valid=0 and res_err=0 next cycle, go to IDLE.
  - A start in the same cycle as the DONE→IDLE handshake is ignored; it must be reapplied in IDLE.
- dp_valid outside WAIT is ignored: no state or acc change.
- The scheduler never issues a second chunk before the previous result returns, so there is at most one transaction in flight.
- Per-chunk latency: 1 (issue register) + datapath latency + 1 (capture). No combinational path from dp_valid to dp_ready.
- Reset mid-operation: an in-flight datapath result arriving after reset is ignored, because the scheduler is in IDLE.

Decomposition:
- dot_product_pkg:
  - state enum sched_state_t {IDLE, ISSUE, WAIT, DONE}
  - FP_ZERO constant (32'h0000_0000)
  - function last_chunk_mask(len, NUM_INPUTS)
- One sub-module, dp_watchdog: a clear/enable counter with parameter TIMEOUT and an expired output.

Test Plan:
- NUM_INPUTS=7, len=7, a=b=1.0 (0x3F800000): one chunk, dp_enable=7'h7F, dp_c=0 → res_data=7.0 (0x40E00000), res_err=0.
- len=10, a=1.0, b=2.0: two issues. Chunk 1 has dp_c=0 and dp_enable=7'h7F. Chunk 2 has dp_c=14.0 (0x41600000) and dp_enable=7'h07 → res_data=20.0 (0x41A00000).
- len=0: start → res_valid next cycle with res_data=0 and no dp_ready pulse. in_valid held high stays unaccepted.
- Datapath model that never asserts dp_valid, len=7: after issue, res_valid with res_err=1 within TIMEOUT+2 cycles, res_data=0.
- res_ready held low 20 cycles after completion: res_valid and res_data stable throughout. Spurious dp_valid pulses in DONE and IDLE cause no change.
- rst asserted while in WAIT: all outputs 0 immediately. A late dp_valid is ignored. A fresh start with len=7 gives 7.0 correctly.

Source files
------------

// File: rtl/dot_product_scheduler_pkg.sv
// Shared types and helpers for the dot-product scheduler.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: sched_state_t FSM encoding, FP_ZERO constant, last_chunk_mask().
package dot_product_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } sched_state_t;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;

   // Upper bound on lane count the mask helper can express; callers
   // truncate the result to their own lane count.
   localparam int MASK_W = 64;

   // Lane mask for the final chunk of a len-element vector: the low
   // (len mod num_inputs) lanes, or every lane when the vector fills
   // the last chunk exactly.
   function automatic logic [MASK_W-1:0] last_chunk_mask(input int len, input int num_inputs);
      logic [MASK_W-1:0] ones;
      int rem;
      ones = '1;
      rem  = len % num_inputs;
      if (rem == 0) begin
         return ones >> (MASK_W - num_inputs);
      end
      return (MASK_W'(1) << rem) - MASK_W'(1);
   endfunction

endpackage

// File: rtl/dot_product_scheduler_if.sv
// Bundle of the scheduler's chunk-in, datapath and result channels.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on chunks, res_valid/res_ready on results.
// Modports: master = scheduler side, slave = surrounding fetch/datapath/consumer.
interface dot_product_scheduler_if #(
   parameter int WIDTH      = 32,
   parameter int NUM_INPUTS = 7,
   parameter int LEN_W      = 9
);
   // control
   logic                        start;
   logic [LEN_W-1:0]            cfg_len;
   logic                        busy;
   // chunk input stream
   logic [WIDTH*NUM_INPUTS-1:0] in_a;
   logic [WIDTH*NUM_INPUTS-1:0] in_b;
   logic                        in_valid;
   logic                        in_ready;
   // dot-product datapath
   logic [WIDTH*NUM_INPUTS-1:0] dp_a;
   logic [WIDTH*NUM_INPUTS-1:0] dp_b;
   logic [WIDTH-1:0]            dp_c;
   logic [NUM_INPUTS-1:0]       dp_enable;
   logic                        dp_ready;
   logic                        dp_valid;
   logic [WIDTH-1:0]            dp_out;
   // result stream
   logic [WIDTH-1:0]            res_data;
   logic                        res_err;
   logic                        res_valid;
   logic                        res_ready;

   modport master (
      input  start, cfg_len, in_a, in_b, in_valid, dp_valid, dp_out, res_ready,
      output busy, in_ready, dp_a, dp_b, dp_c, dp_enable, dp_ready,
             res_data, res_err, res_valid
   );

   modport slave (
      output start, cfg_len, in_a, in_b, in_valid, dp_valid, dp_out, res_ready,
      input  busy, in_ready, dp_a, dp_b, dp_c, dp_enable, dp_ready,
             res_data, res_err, res_valid
   );
endinterface

// File: rtl/dot_product_scheduler_dp_watchdog.sv
// Cycle counter bounding how long the scheduler waits for a datapath result.
// Latency: expired rises TIMEOUT-1 enabled cycles after clear.
// Backpressure: none; the count holds once expired until cleared.
// Ports: clk, rst (async active-low), clear, enable, expired.
module dp_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = (count == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/dot_product_scheduler.sv
// Splits long vectors into NUM_INPUTS-wide chunks for the FP dot-product unit,
// chaining each chunk's result into the next chunk's c input.
// Latency per chunk: 1 issue register + datapath latency + 1 capture.
// Backpressure: in_ready only in ISSUE (one chunk in flight); result held until res_ready.
// Ports: clk, rst (async active-low), bus (dot_product_scheduler_if.master).
module dot_product_scheduler
   import dot_product_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int NUM_INPUTS = 7,
   parameter int MAX_LEN    = 256,
   parameter int LEN_W      = $clog2(MAX_LEN + 1),
   parameter int TIMEOUT    = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   dot_product_scheduler_if.master bus
);

   sched_state_t     state, state_nxt;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] num_chunks;
   logic [LEN_W-1:0] chunk_cnt;
   logic [WIDTH-1:0] acc;
   logic [LEN_W-1:0] len_clamped;
   logic             accept;
   logic             last_chunk;
   logic             wd_expired;

   assign len_clamped = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;
   assign accept      = (state == ISSUE) && bus.in_valid;
   assign last_chunk  = (chunk_cnt == num_chunks - LEN_W'(1));

   dp_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (accept),
      .enable  (state == WAIT),
      .expired (wd_expired)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = (len_clamped == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (bus.in_valid) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            // A result landing on the expiry cycle still counts.
            if (bus.dp_valid) begin
               state_nxt = last_chunk ? DONE : ISSUE;
            end else if (wd_expired) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            // start is not looked at here, so a start coinciding with the
            // result handshake is dropped.
            if (bus.res_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      bus.busy      = (state != IDLE);
      bus.in_ready  = (state == ISSUE);
      bus.res_valid = (state == DONE);
   end

   // Issue registers, accumulator and result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q         <= '0;
         num_chunks    <= '0;
         chunk_cnt     <= '0;
         acc           <= '0;
         bus.dp_a      <= '0;
         bus.dp_b      <= '0;
         bus.dp_c      <= '0;
         bus.dp_enable <= '0;
         bus.dp_ready  <= 1'b0;
         bus.res_data  <= '0;
         bus.res_err   <= 1'b0;
      end else begin
         // Single-cycle issue strobe; registered, so dp_valid never
         // reaches it combinationally.
         bus.dp_ready <= accept;

         case (state)
            IDLE: begin
               if (bus.start) begin
                  len_q      <= len_clamped;
                  num_chunks <= LEN_W'((32'(len_clamped) + NUM_INPUTS - 1) / NUM_INPUTS);
                  chunk_cnt  <= '0;
                  acc        <= WIDTH'(FP_ZERO);
                  if (len_clamped == '0) begin
                     bus.res_data <= WIDTH'(FP_ZERO);
                     bus.res_err  <= 1'b0;
                  end
               end
            end
            ISSUE: begin
               if (accept) begin
                  bus.dp_a      <= bus.in_a;
                  bus.dp_b      <= bus.in_b;
                  bus.dp_c      <= acc;
                  bus.dp_enable <= last_chunk ?
                                   NUM_INPUTS'(last_chunk_mask(int'(len_q), NUM_INPUTS)) : '1;
               end
            end
            WAIT: begin
               if (bus.dp_valid) begin
                  acc       <= bus.dp_out;
                  chunk_cnt <= chunk_cnt + LEN_W'(1);
                  if (last_chunk) begin
                     bus.res_data <= bus.dp_out;
                     bus.res_err  <= 1'b0;
                  end
               end else if (wd_expired) begin
                  // Abort with whatever partial sum had accumulated.
                  bus.res_data <= acc;
                  bus.res_err  <= 1'b1;
               end
            end
            DONE: begin
               if (bus.res_ready) begin
                  bus.res_err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Directed bench for dot_product_scheduler with a behavioural FP datapath model.
module tb_dot_product_scheduler;

   localparam int WIDTH   = 32;
   localparam int NI      = 7;
   localparam int MAX_LEN = 256;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);
   localparam int TIMEOUT = 64;
   localparam int LAT     = 3;

   localparam logic [31:0] FP_ONE    = 32'h3F80_0000;
   localparam logic [31:0] FP_TWO    = 32'h4000_0000;
   localparam logic [31:0] FP_SEVEN  = 32'h40E0_0000;
   localparam logic [31:0] FP_14     = 32'h4160_0000;
   localparam logic [31:0] FP_20     = 32'h41A0_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dot_product_scheduler_if #(.WIDTH(WIDTH), .NUM_INPUTS(NI), .LEN_W(LEN_W)) bus ();

   dot_product_scheduler #(
      .WIDTH(WIDTH), .NUM_INPUTS(NI), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Datapath result path is shared between the model and spurious pulses.
   logic        dp_valid_m;
   logic [31:0] dp_out_m;
   logic        spur_vld;
   logic [31:0] spur_dat;
   logic        dp_dead;
   assign bus.dp_valid = dp_valid_m | spur_vld;
   assign bus.dp_out   = spur_vld ? spur_dat : dp_out_m;

   logic [31:0]   cap_c  [0:15];
   logic [NI-1:0] cap_en [0:15];
   int            issue_cnt = 0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic real fp2real(input logic [31:0] f);
      logic [63:0] d;
      logic [10:0] e;
      if (f[30:0] == 31'd0) return 0.0;
      e = 11'(int'(f[30:23]) - 127 + 1023);
      d = {f[31], e, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] real2fp(input real r);
      logic [63:0] d;
      logic [7:0]  e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = 8'(int'(d[62:52]) - 1023 + 127);
      return {d[63], e, d[51:29]};
   endfunction

   // Behavioural datapath: c + sum of enabled a*b lanes, LAT cycles after issue.
   initial begin : dp_model
      real         s;
      logic [31:0] r;
      dp_valid_m = 1'b0;
      dp_out_m   = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.dp_ready) begin
            if (issue_cnt < 16) begin
               cap_c[issue_cnt]  = bus.dp_c;
               cap_en[issue_cnt] = bus.dp_enable;
            end
            issue_cnt++;
            s = fp2real(bus.dp_c);
            for (int i = 0; i < NI; i++) begin
               if (bus.dp_enable[i]) begin
                  s = s + fp2real(bus.dp_a[i*32 +: 32]) * fp2real(bus.dp_b[i*32 +: 32]);
               end
            end
            r = real2fp(s);
            if (!dp_dead) begin
               repeat (LAT) @(posedge clk);
               #1;
               dp_valid_m = 1'b1;
               dp_out_m   = r;
               @(posedge clk);
               #1;
               dp_valid_m = 1'b0;
            end
         end
      end
   end

   initial begin : global_guard
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic start_vec(input int len, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.cfg_len  = LEN_W'(len);
      bus.in_a     = {NI{a}};
      bus.in_b     = {NI{b}};
      bus.in_valid = 1'b1;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
   endtask

   task automatic wait_res(input string tag);
      int cyc;
      cyc = 0;
      while (!bus.res_valid && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_res_valid"}, 256'(bus.res_valid), 256'(1));
   endtask

   task automatic wait_issue(input string tag);
      int cyc;
      cyc = 0;
      while (!bus.dp_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_issue"}, 256'(bus.dp_ready), 256'(1));
   endtask

   task automatic handshake(input string tag);
      @(negedge clk);
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      check({tag, "_res_valid_clr"}, 256'(bus.res_valid), 256'(0));
      check({tag, "_busy_clr"}, 256'(bus.busy), 256'(0));
   endtask

   initial begin : stim
      int base;
      int cyc;
      bus.start     = 1'b0;
      bus.cfg_len   = '0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_valid  = 1'b0;
      bus.res_ready = 1'b0;
      spur_vld      = 1'b0;
      spur_dat      = '0;
      dp_dead       = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy",      256'(bus.busy),      256'(0));
      check("rst_in_ready",  256'(bus.in_ready),  256'(0));
      check("rst_res_valid", 256'(bus.res_valid), 256'(0));
      check("rst_res_err",   256'(bus.res_err),   256'(0));
      check("rst_res_data",  256'(bus.res_data),  256'(0));
      check("rst_dp_ready",  256'(bus.dp_ready),  256'(0));
      check("rst_dp_enable", 256'(bus.dp_enable), 256'(0));
      check("rst_dp_a",      256'(bus.dp_a),      256'(0));
      rst = 1'b1;

      // len=7, a=b=1.0: single full chunk
      base = issue_cnt;
      start_vec(7, FP_ONE, FP_ONE);
      wait_res("v7");
      bus.in_valid = 1'b0;
      check("v7_issues",  256'(issue_cnt - base),  256'(1));
      check("v7_c",       256'(cap_c[base]),       256'(32'h0));
      check("v7_en",      256'(cap_en[base]),      256'(7'h7F));
      check("v7_data",    256'(bus.res_data),      256'(FP_SEVEN));
      check("v7_err",     256'(bus.res_err),       256'(0));
      handshake("v7");

      // len=10, a=1.0, b=2.0: two chunks, last masked to 3 lanes
      base = issue_cnt;
      start_vec(10, FP_ONE, FP_TWO);
      wait_res("v10");
      bus.in_valid = 1'b0;
      check("v10_issues", 256'(issue_cnt - base),  256'(2));
      check("v10_c0",     256'(cap_c[base]),       256'(32'h0));
      check("v10_en0",    256'(cap_en[base]),      256'(7'h7F));
      check("v10_c1",     256'(cap_c[base+1]),     256'(FP_14));
      check("v10_en1",    256'(cap_en[base+1]),    256'(7'h07));
      check("v10_data",   256'(bus.res_data),      256'(FP_20));
      check("v10_err",    256'(bus.res_err),       256'(0));

      // Result held under backpressure, spurious dp_valid in DONE ignored
      spur_dat = 32'hDEAD_BEEF;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         spur_vld = (i == 5 || i == 12);
         check("hold_valid", 256'(bus.res_valid), 256'(1));
         check("hold_data",  256'(bus.res_data),  256'(FP_20));
      end
      @(negedge clk);
      spur_vld = 1'b0;
      check("hold_data_after_spur", 256'(bus.res_data), 256'(FP_20));
      handshake("v10");

      // Spurious dp_valid in IDLE
      @(negedge clk);
      spur_vld = 1'b1;
      @(negedge clk);
      spur_vld = 1'b0;
      check("idle_spur_busy",     256'(bus.busy),      256'(0));
      check("idle_spur_valid",    256'(bus.res_valid), 256'(0));
      check("idle_spur_dp_ready", 256'(bus.dp_ready),  256'(0));

      // len=0: straight to DONE, chunk never accepted
      base = issue_cnt;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.cfg_len  = '0;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      check("z_res_valid", 256'(bus.res_valid), 256'(1));
      check("z_res_data",  256'(bus.res_data),  256'(0));
      check("z_res_err",   256'(bus.res_err),   256'(0));
      check("z_in_ready",  256'(bus.in_ready),  256'(0));
      @(negedge clk);
      check("z_issues",    256'(issue_cnt - base), 256'(0));
      // start coincident with the result handshake is dropped
      bus.res_ready = 1'b1;
      bus.start     = 1'b1;
      bus.cfg_len   = LEN_W'(7);
      @(negedge clk);
      bus.res_ready = 1'b0;
      bus.start     = 1'b0;
      check("z_hs_start_busy", 256'(bus.busy), 256'(0));
      @(negedge clk);
      check("z_hs_start_busy2", 256'(bus.busy), 256'(0));
      check("z_hs_issues", 256'(issue_cnt - base), 256'(0));
      bus.in_valid = 1'b0;

      // Datapath never answers: watchdog abort
      dp_dead = 1'b1;
      start_vec(7, FP_ONE, FP_ONE);
      wait_issue("to");
      bus.in_valid = 1'b0;
      cyc = 0;
      while (!bus.res_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("to_res_valid", 256'(bus.res_valid), 256'(1));
      check("to_res_err",   256'(bus.res_err),   256'(1));
      check("to_res_data",  256'(bus.res_data),  256'(0));
      check("to_latency_in_range",
            256'((cyc >= TIMEOUT - 1) && (cyc <= TIMEOUT + 2)), 256'(1));
      handshake("to");
      check("to_err_clr", 256'(bus.res_err), 256'(0));
      dp_dead = 1'b0;

      // Reset while waiting on the datapath; late result must be ignored
      start_vec(7, FP_ONE, FP_ONE);
      wait_issue("rw");
      bus.in_valid = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      check("rw_busy",      256'(bus.busy),      256'(0));
      check("rw_dp_ready",  256'(bus.dp_ready),  256'(0));
      check("rw_dp_a",      256'(bus.dp_a),      256'(0));
      check("rw_dp_c",      256'(bus.dp_c),      256'(0));
      check("rw_dp_enable", 256'(bus.dp_enable), 256'(0));
      check("rw_res_valid", 256'(bus.res_valid), 256'(0));
      check("rw_res_data",  256'(bus.res_data),  256'(0));
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      check("rw_late_busy",  256'(bus.busy),      256'(0));
      check("rw_late_valid", 256'(bus.res_valid), 256'(0));
      check("rw_late_data",  256'(bus.res_data),  256'(0));

      base = issue_cnt;
      start_vec(7, FP_ONE, FP_ONE);
      wait_res("rw7");
      bus.in_valid = 1'b0;
      check("rw7_issues", 256'(issue_cnt - base), 256'(1));
      check("rw7_c",      256'(cap_c[base]),      256'(32'h0));
      check("rw7_data",   256'(bus.res_data),     256'(FP_SEVEN));
      check("rw7_err",    256'(bus.res_err),      256'(0));
      handshake("rw7");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
